spatz_req_dispatcher: RTL and testbench

SPATZ_REQ_DISPATCHER -- requirements
Module: spatz_req_dispatcher

---
 rtl/spatz_pkg.sv | 28 ++
 rtl/spatz_scoreboard.sv | 41 ++++
 rtl/spatz_req_dispatcher.sv | 101 ++++++++++
 tb/tb_spatz_req_dispatcher.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/spatz_pkg.sv
// Shared types for the Spatz request path: decoded request, unit IDs and the
// vector-register scoreboard vector.
package spatz_pkg;

  localparam int unsigned NRVREG = 32;

  typedef logic [$clog2(NRVREG)-1:0] opreg_t;
  typedef logic [NRVREG-1:0]         vreg_sb_t;

  typedef enum logic [1:0] {
    CON = 2'd0,
    LSU = 2'd1,
    SLD = 2'd2,
    VFU = 2'd3
  } ex_unit_e;

  typedef struct packed {
    ex_unit_e   ex_unit;
    logic       use_vs1;
    logic       use_vs2;
    logic       use_vd;
    opreg_t     vs1;
    opreg_t     vs2;
    opreg_t     vd;
    logic [7:0] op;
  } spatz_req_t;

endpackage

// File: rtl/spatz_scoreboard.sv
// Per-vreg busy bits: set on dispatch of a writer, cleared on unit retire.
// Hazard lookup for the head request uses only the registered busy vector.
module spatz_scoreboard
  import spatz_pkg::*;
#(
  parameter int unsigned NrUnits = 4,
  parameter int unsigned NrVReg  = NRVREG
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      set_valid_i,
  input  opreg_t                    set_vd_i,
  input  logic [NrUnits-1:0]        retire_valid_i,
  input  opreg_t [NrUnits-1:0]      retire_vd_i,
  input  spatz_req_t                head_i,
  output logic                      hazard_o,
  output logic [NrVReg-1:0]         busy_o
);

  logic [NrVReg-1:0] r_busy;
  logic [NrVReg-1:0] w_busy_d;

  // Set is applied after the clears so a same-cycle set/clear leaves the bit set.
  always_comb begin
    w_busy_d = r_busy;
    for (int u = 0; u < int'(NrUnits); u++)
      if (retire_valid_i[u]) w_busy_d[retire_vd_i[u]] = 1'b0;
    if (set_valid_i) w_busy_d[set_vd_i] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_busy <= '0;
    else         r_busy <= w_busy_d;
  end

  assign hazard_o = (head_i.use_vs1 && r_busy[head_i.vs1]) ||
                    (head_i.use_vs2 && r_busy[head_i.vs2]) ||
                    (head_i.use_vd  && r_busy[head_i.vd]);
  assign busy_o   = r_busy;

endmodule

// File: rtl/spatz_req_dispatcher.sv
// In-order decoded-request buffer dispatching the head to its execution unit.
// Optional SPATZ_REQ_BYPASS_EN: zero-latency empty-buffer bypass and full push-while-pop.
module spatz_req_dispatcher
  import spatz_pkg::*;
#(
  parameter int unsigned Depth   = 4,
  parameter int unsigned NrUnits = 4,
  parameter int unsigned NrVReg  = NRVREG
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  spatz_req_t           req_i,
  input  logic                 flush_i,
  output logic [NrUnits-1:0]   disp_valid_o,
  input  logic [NrUnits-1:0]   disp_ready_i,
  output spatz_req_t           disp_req_o,
  input  logic [NrUnits-1:0]   retire_valid_i,
  input  opreg_t [NrUnits-1:0] retire_vd_i,
  output logic [NrVReg-1:0]    busy_o,
  output logic                 empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  spatz_req_t        r_mem [Depth];
  logic [PtrW-1:0]   r_rd_ptr, r_wr_ptr;
  logic [CntW-1:0]   r_cnt;

  spatz_req_t        w_head;
  logic              w_head_vld, w_hazard, w_buf_empty, w_cnt_free;
  logic              w_pop, w_push, w_push_mem, w_pop_mem;
  logic [NrUnits-1:0] w_disp_valid;

  assign w_buf_empty = (r_cnt == '0);
  assign w_cnt_free  = (r_cnt < CntW'(Depth));

`ifdef SPATZ_REQ_BYPASS_EN
  // An empty buffer exposes req_i directly; a bypassed request never lands in r_mem.
  assign w_head      = w_buf_empty ? req_i : r_mem[r_rd_ptr];
  assign w_head_vld  = w_buf_empty ? req_valid_i : 1'b1;
  assign req_ready_o = w_cnt_free || w_pop;
  assign w_push_mem  = w_push && !(w_buf_empty && w_pop);
  assign w_pop_mem   = w_pop && !w_buf_empty;
`else
  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_vld  = !w_buf_empty;
  assign req_ready_o = w_cnt_free;
  assign w_push_mem  = w_push;
  assign w_pop_mem   = w_pop;
`endif

  always_comb begin
    w_disp_valid = '0;
    if (w_head_vld && !w_hazard && !flush_i) w_disp_valid[w_head.ex_unit] = 1'b1;
  end

  assign w_pop        = |(w_disp_valid & disp_ready_i);
  assign w_push       = req_valid_i && req_ready_o && !flush_i;
  assign disp_valid_o = w_disp_valid;
  assign disp_req_o   = w_head;
  assign empty_o      = w_buf_empty && (busy_o == '0);

  always_ff @(posedge clk_i) begin
    if (w_push_mem) r_mem[r_wr_ptr] <= req_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push_mem) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop_mem)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      r_cnt <= r_cnt + CntW'(w_push_mem) - CntW'(w_pop_mem);
    end
  end

  spatz_scoreboard #(
    .NrUnits (NrUnits),
    .NrVReg  (NrVReg)
  ) i_sb (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .set_valid_i    (w_pop && w_head.use_vd),
    .set_vd_i       (w_head.vd),
    .retire_valid_i (retire_valid_i),
    .retire_vd_i    (retire_vd_i),
    .head_i         (w_head),
    .hazard_o       (w_hazard),
    .busy_o         (busy_o)
  );

endmodule

// File: tb/tb_spatz_req_dispatcher.sv
// Directed bench for spatz_req_dispatcher in its default (no bypass) build.
module tb_spatz_req_dispatcher;
  import spatz_pkg::*;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          req_valid_i;
  logic          req_ready_o;
  spatz_req_t    req_i;
  logic          flush_i;
  logic [3:0]    disp_valid_o;
  logic [3:0]    disp_ready_i;
  spatz_req_t    disp_req_o;
  logic [3:0]    retire_valid_i;
  opreg_t [3:0]  retire_vd_i;
  logic [31:0]   busy_o;
  logic          empty_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  spatz_req_dispatcher #(.Depth(4), .NrUnits(4), .NrVReg(32)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_i          (req_i),
    .flush_i        (flush_i),
    .disp_valid_o   (disp_valid_o),
    .disp_ready_i   (disp_ready_i),
    .disp_req_o     (disp_req_o),
    .retire_valid_i (retire_valid_i),
    .retire_vd_i    (retire_vd_i),
    .busy_o         (busy_o),
    .empty_o        (empty_o)
  );

  function automatic spatz_req_t mk(ex_unit_e u, logic r1, logic r2, logic wd,
                                    opreg_t a, opreg_t b, opreg_t d, logic [7:0] op);
    spatz_req_t r;
    r.ex_unit = u; r.use_vs1 = r1; r.use_vs2 = r2; r.use_vd = wd;
    r.vs1 = a; r.vs2 = b; r.vd = d; r.op = op;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_ni = 1'b0; req_valid_i = 1'b0; req_i = '0; flush_i = 1'b0;
    disp_ready_i = '0; retire_valid_i = '0; retire_vd_i = '0;
    #3;
    chk("rst_ready", req_ready_o, 1);
    chk("rst_empty", empty_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_disp", disp_valid_o, 0);
    @(negedge clk_i) rst_ni = 1'b1;

    // VADD vd=3 on VFU: one-cycle latency, then busy[3]
    req_i = mk(VFU, 0, 0, 1, 0, 0, 3, 8'h01); req_valid_i = 1'b1; disp_ready_i = 4'b1000;
    #1 chk("vadd_lat0", disp_valid_o, 0);
    @(negedge clk_i) req_valid_i = 1'b0;
    #1 chk("vadd_disp", disp_valid_o, 4'b1000);
    chk("vadd_vd", disp_req_o.vd, 3);
    @(negedge clk_i);
    chk("vadd_busy", busy_o, 32'h8);
    chk("vadd_done", disp_valid_o, 0);
    chk("vadd_nempty", empty_o, 0);

    // VMUL reads vs2=3: stalls until retire of v3 is registered
    req_i = mk(VFU, 0, 1, 1, 0, 3, 4, 8'h02); req_valid_i = 1'b1;
    @(negedge clk_i) req_valid_i = 1'b0;
    #1 chk("vmul_stall0", disp_valid_o, 0);
    @(negedge clk_i);
    chk("vmul_stall1", disp_valid_o, 0);
    retire_valid_i = 4'b1000; retire_vd_i[3] = 5'd3;
    #1 chk("vmul_nobypass", disp_valid_o, 0);
    @(negedge clk_i) retire_valid_i = '0;
    #1 chk("vmul_clr", busy_o, 0);
    chk("vmul_disp", disp_valid_o, 4'b1000);
    chk("vmul_op", disp_req_o.op, 8'h02);
    @(negedge clk_i);
    chk("vmul_busy4", busy_o, 32'h10);
    chk("vmul_done", disp_valid_o, 0);

    // Fill with LSU ops while no unit is ready (pointers wrap here)
    disp_ready_i = '0;
    for (int i = 0; i < 4; i++) begin
      req_i = mk(LSU, 0, 0, 0, 0, 0, 0, 8'h10 + 8'(i)); req_valid_i = 1'b1;
      @(negedge clk_i);
    end
    req_i = mk(LSU, 0, 0, 0, 0, 0, 0, 8'h20);
    #1 chk("full_ready", req_ready_o, 0);
    chk("full_disp", disp_valid_o, 4'b0010);
    chk("full_head", disp_req_o.op, 8'h10);
    @(negedge clk_i) req_valid_i = 1'b0;
    chk("refused_ready", req_ready_o, 0);
    chk("stable_head", disp_req_o.op, 8'h10);
    disp_ready_i = 4'b0010;
    #1 chk("pop_disp", disp_valid_o, 4'b0010);
    @(negedge clk_i) disp_ready_i = '0;
    #1 chk("pop_ready", req_ready_o, 1);
    chk("pop_head", disp_req_o.op, 8'h11);

    // Flush with 3 buffered; v4 stays busy, concurrent push ignored
    flush_i = 1'b1; req_valid_i = 1'b1; req_i = mk(LSU, 0, 0, 0, 0, 0, 0, 8'h30);
    #1 chk("flush_disp", disp_valid_o, 0);
    @(negedge clk_i) flush_i = 1'b0; req_valid_i = 1'b0;
    #1 chk("flush_empty", disp_valid_o, 0);
    chk("flush_ready", req_ready_o, 1);
    chk("flush_busy", busy_o, 32'h10);
    chk("flush_nempty", empty_o, 0);
    req_i = mk(LSU, 0, 0, 0, 0, 0, 0, 8'h40); req_valid_i = 1'b1; disp_ready_i = 4'b0010;
    @(negedge clk_i) req_valid_i = 1'b0;
    #1 chk("postflush_disp", disp_valid_o, 4'b0010);
    chk("postflush_op", disp_req_o.op, 8'h40);
    @(negedge clk_i) disp_ready_i = '0;
    retire_valid_i = 4'b0001; retire_vd_i[0] = 5'd4;
    @(negedge clk_i) retire_valid_i = '0;
    #1 chk("drain_busy", busy_o, 0);
    chk("drain_empty", empty_o, 1);

    // Dispatch vd=5 with a same-cycle retire of v5: set wins
    req_i = mk(VFU, 0, 0, 1, 0, 0, 5, 8'h50); req_valid_i = 1'b1; disp_ready_i = 4'b1000;
    @(negedge clk_i) req_valid_i = 1'b0;
    retire_valid_i = 4'b0100; retire_vd_i[2] = 5'd5;
    #1 chk("setclr_disp", disp_valid_o, 4'b1000);
    @(negedge clk_i) retire_valid_i = '0;
    #1 chk("setclr_busy", busy_o, 32'h20);
    retire_valid_i = 4'b0001; retire_vd_i[0] = 5'd7;
    @(negedge clk_i) retire_valid_i = '0;
    #1 chk("idle_retire", busy_o, 32'h20);

    // Async reset while a dispatch is pending
    req_i = mk(LSU, 0, 0, 0, 0, 0, 0, 8'h60); req_valid_i = 1'b1; disp_ready_i = '0;
    @(negedge clk_i) req_valid_i = 1'b0;
    #1 chk("prerst_disp", disp_valid_o, 4'b0010);
    #2 rst_ni = 1'b0;
    #1 chk("arst_disp", disp_valid_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_ready", req_ready_o, 1);
    chk("arst_empty", empty_o, 1);
    @(negedge clk_i) rst_ni = 1'b1;
    #1 chk("postrst_disp", disp_valid_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
